// File: rtl/posit_mac_accum_if.sv
// Handshake bundle for the posit MAC accumulator: decoded operand pairs in,
// one fixed-point group sum plus NaR flag out.
interface posit_mac_accum_if #(
  parameter int WIDTH   = 8,
  parameter int EXP     = 2,
  parameter int ACC_LEN = 16
);
  localparam int MTS  = WIDTH-3-EXP;
  localparam int REGI = $clog2(WIDTH)+1;
  localparam int BIAS = (2**(EXP+1))*(WIDTH-2);
  localparam int QW   = 2*BIAS + 2**(EXP+1) + 2*MTS + $clog2(ACC_LEN) + 1;

  logic                   in_vld;
  logic                   in_rdy;
  logic                   sign_s, sign_l;
  logic signed [REGI-1:0] regi_s, regi_l;
  logic [EXP-1:0]         exp_s, exp_l;
  logic [MTS-1:0]         mts_s, mts_l;
  logic [1:0]             vld_o_w, vld_o_d;
  logic                   out_vld;
  logic                   out_rdy;
  logic signed [QW-1:0]   acc_o;
  logic                   nar_o;

  modport master (
    output in_vld, sign_s, sign_l, regi_s, regi_l, exp_s, exp_l,
           mts_s, mts_l, vld_o_w, vld_o_d, out_rdy,
    input  in_rdy, out_vld, acc_o, nar_o
  );

  modport slave (
    input  in_vld, sign_s, sign_l, regi_s, regi_l, exp_s, exp_l,
           mts_s, mts_l, vld_o_w, vld_o_d, out_rdy,
    output in_rdy, out_vld, acc_o, nar_o
  );
endinterface

// File: rtl/posit_mac_accum.sv
// Exact posit product accumulator: stage 1 forms sign/scale/mantissa product,
// stage 2 aligns into a wide fixed-point accumulator, one result per ACC_LEN pairs.
module posit_mac_accum #(
  parameter int WIDTH   = 8,
  parameter int EXP     = 2,
  parameter int ACC_LEN = 16
) (
  input logic              clk_i,
  input logic              rst,
  posit_mac_accum_if.slave bus
);
  localparam int MTS  = WIDTH-3-EXP;
  localparam int REGI = $clog2(WIDTH)+1;
  localparam int BIAS = (2**(EXP+1))*(WIDTH-2);
  localparam int QW   = 2*BIAS + 2**(EXP+1) + 2*MTS + $clog2(ACC_LEN) + 1;
  localparam int MW   = 2*MTS+2;
  localparam int CW   = $clog2(ACC_LEN);
  // scale plus bias headroom, signed
  localparam int SCW  = $clog2(BIAS+1) + REGI + EXP + 3;

  logic en, take;
  assign en         = ~(bus.out_vld & ~bus.out_rdy);
  assign bus.in_rdy = en;
  assign take       = bus.in_vld & en;

  logic                  p_vld, p_sign, p_zero, p_nar;
  logic signed [SCW-1:0] p_scale;
  logic [MW-1:0]         p_mprod;

  logic signed [SCW-1:0] scale_d;
  logic [MW-1:0]         mprod_d;

  always_comb begin
    scale_d = ((SCW'(bus.regi_s) + SCW'(bus.regi_l)) <<< EXP)
            + $signed(SCW'(bus.exp_s)) + $signed(SCW'(bus.exp_l));
    mprod_d = MW'({1'b1, bus.mts_s}) * MW'({1'b1, bus.mts_l});
  end

  logic signed [SCW-1:0] sh;
  logic [QW-1:0]         mag;
  logic signed [QW-1:0]  term, acc, sum;
  logic [CW-1:0]         cnt;
  logic                  sticky;

  // Negative shifts cannot arise from legal decoder regimes; they right-shift.
  always_comb begin
    sh  = p_scale + SCW'(BIAS);
    mag = QW'(p_mprod);
    if (sh[SCW-1]) mag = mag >> (-sh);
    else           mag = mag << sh;
    term = (p_zero | p_nar) ? '0 : (p_sign ? -$signed(mag) : $signed(mag));
    sum  = acc + term;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      p_vld       <= 1'b0;
      p_sign      <= 1'b0;
      p_zero      <= 1'b0;
      p_nar       <= 1'b0;
      p_scale     <= '0;
      p_mprod     <= '0;
      cnt         <= '0;
      acc         <= '0;
      sticky      <= 1'b0;
      bus.acc_o   <= '0;
      bus.nar_o   <= 1'b0;
      bus.out_vld <= 1'b0;
    end else if (en) begin
      p_vld <= take;
      if (take) begin
        p_sign  <= bus.sign_s ^ bus.sign_l;
        p_scale <= scale_d;
        p_mprod <= mprod_d;
        p_zero  <= (bus.vld_o_w == 2'b00) | (bus.vld_o_d == 2'b00);
        p_nar   <= (bus.vld_o_w == 2'b10) | (bus.vld_o_d == 2'b10);
      end
      // Closing term goes straight to the output; the group state restarts at zero.
      if (p_vld && (&cnt)) begin
        bus.acc_o   <= sum;
        bus.nar_o   <= sticky | p_nar;
        bus.out_vld <= 1'b1;
        acc         <= '0;
        sticky      <= 1'b0;
        cnt         <= '0;
      end else begin
        bus.out_vld <= 1'b0;
        if (p_vld) begin
          acc    <= sum;
          sticky <= sticky | p_nar;
          cnt    <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_posit_mac_accum.sv
// Scoreboard bench: the driver pushes expected group sums from a real-valued
// operand model, a negedge monitor pops and compares on each output handshake.
module tb_posit_mac_accum;
  localparam int WIDTH = 8, EXP = 2, ACC_LEN = 16;
  localparam int REGI = 4, MTS = 3;

  logic clk_i = 1'b0;
  logic rst   = 1'b1;
  always #5 clk_i = ~clk_i;

  posit_mac_accum_if #(.WIDTH(WIDTH), .EXP(EXP), .ACC_LEN(ACC_LEN)) bus();
  posit_mac_accum #(.WIDTH(WIDTH), .EXP(EXP), .ACC_LEN(ACC_LEN)) dut (
    .clk_i(clk_i), .rst(rst), .bus(bus));

  typedef struct { logic signed [127:0] acc; logic nar; } res_t;
  res_t exp_q[$];
  res_t mon_r;

  int n_chk = 0, n_err = 0, n_out = 0, n_push = 0, stalls = 0, k2;
  logic signed [127:0] part;
  logic part_nar;
  int part_cnt;

  // out_rdy: 0 = held high, 1 = held low, 2 = random
  int rdy_mode = 0;
  logic rnd_bit = 1'b1;
  assign bus.out_rdy = (rdy_mode == 0) | ((rdy_mode == 2) & rnd_bit);
  always @(posedge clk_i) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  function automatic void chk(string nm, logic [127:0] got, logic [127:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endfunction

  function automatic logic signed [127:0] p2(int n);
    logic signed [127:0] v;
    v = 128'(1);
    return v <<< n;
  endfunction

  // Operand value in units of 2^-27: (1 + m/8) * 2^(4r+e), so products land in units of 2^-54.
  function automatic logic signed [127:0] opval(logic s, int r, int e, int m);
    logic signed [127:0] v;
    v = 128'(8 + m);
    v = v <<< (4*r + e + 24);
    return s ? -v : v;
  endfunction

  function automatic logic [1:0] rcls();
    int r;
    r = int'($urandom_range(0, 9));
    return (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b01;
  endfunction

  always @(negedge clk_i) begin
    if (!rst && bus.out_vld && bus.out_rdy) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_result: got acc %0h, none due", bus.acc_o);
      end else begin
        mon_r = exp_q.pop_front();
        chk("acc_o", 128'(bus.acc_o), mon_r.acc);
        chk("nar_o", 128'(bus.nar_o), 128'(mon_r.nar));
      end
    end
  end

  task automatic send_pair(input logic ss, input int rs, es, ms, input logic [1:0] cs,
                           input logic sl, input int rl, el, ml, input logic [1:0] cl);
    int w;
    w = 0;
    bus.in_vld = 1'b1;
    bus.sign_s = ss; bus.regi_s = REGI'(rs); bus.exp_s = EXP'(es); bus.mts_s = MTS'(ms);
    bus.sign_l = sl; bus.regi_l = REGI'(rl); bus.exp_l = EXP'(el); bus.mts_l = MTS'(ml);
    bus.vld_o_w = cs; bus.vld_o_d = cl;
    @(negedge clk_i);
    while (!bus.in_rdy && w < 200) begin
      w++;
      @(negedge clk_i);
    end
    if (w >= 200) chk("accept_timeout", 128'(bus.in_rdy), 128'(1));
    @(posedge clk_i);
    #1;
    bus.in_vld = 1'b0;
    stalls += w;
    if (cs == 2'b10 || cl == 2'b10) part_nar = 1'b1;
    else if (cs == 2'b01 && cl == 2'b01) part += opval(ss, rs, es, ms) * opval(sl, rl, el, ml);
    part_cnt++;
    if (part_cnt == ACC_LEN) begin
      exp_q.push_back('{acc: part, nar: part_nar});
      n_push++;
      part = '0; part_nar = 1'b0; part_cnt = 0;
    end
  endtask

  task automatic one(input logic s_s, input logic s_l);
    send_pair(s_s, 0, 0, 0, 2'b01, s_l, 0, 0, 0, 2'b01);
  endtask

  task automatic idle(input int n);
    bus.in_vld = 1'b0;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  // Called right after a group's last acceptance with out_rdy high.
  task automatic wait_out(string nm, logic signed [127:0] wa, logic wn);
    int k;
    k = 0;
    do begin @(negedge clk_i); k++; end while (!bus.out_vld && k < 50);
    chk({nm, "_lat"}, 128'(k), 128'(2));
    chk({nm, "_acc"}, 128'(bus.acc_o), wa);
    chk({nm, "_nar"}, 128'(bus.out_vld ? bus.nar_o : 1'bx), 128'(wn));
    @(posedge clk_i); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_vld = 1'b0;
    bus.sign_s = 1'b0; bus.sign_l = 1'b0; bus.regi_s = '0; bus.regi_l = '0;
    bus.exp_s = '0; bus.exp_l = '0; bus.mts_s = '0; bus.mts_l = '0;
    bus.vld_o_w = 2'b01; bus.vld_o_d = 2'b01;
    part = '0; part_nar = 1'b0; part_cnt = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst = 1'b0;
    @(negedge clk_i);
    chk("rst_out_vld", 128'(bus.out_vld), 128'(0));
    chk("rst_acc_o", 128'(bus.acc_o), 128'(0));
    chk("rst_nar_o", 128'(bus.nar_o), 128'(0));
    chk("rst_in_rdy", 128'(bus.in_rdy), 128'(1));
    @(posedge clk_i); #1;

    repeat (16) one(1'b0, 1'b0);
    wait_out("ones", p2(58), 1'b0);

    for (int i = 0; i < 8; i++) begin one(1'b0, 1'b0); one(1'b1, 1'b0); end
    wait_out("cancel", 128'(0), 1'b0);

    for (int i = 0; i < 16; i++)
      if (i == 5) send_pair(1'b0, 0, 0, 0, 2'b01, 1'b0, 0, 0, 0, 2'b10);
      else        one(1'b0, 1'b0);
    wait_out("nar", 15 * p2(54), 1'b1);
    repeat (16) one(1'b0, 1'b0);
    wait_out("nar_clear", p2(58), 1'b0);

    stalls = 0;
    repeat (32) one(1'b0, 1'b0);
    chk("b2b_stalls", 128'(stalls), 128'(0));
    idle(4);

    // Stall: group A completes with out_rdy low, group B must resume intact.
    rdy_mode = 1;
    fork
      begin
        k2 = 0;
        @(negedge clk_i);
        while (!bus.out_vld && k2 < 200) begin k2++; @(negedge clk_i); end
        repeat (4) begin
          @(negedge clk_i);
          chk("stall_in_rdy", 128'(bus.in_rdy), 128'(0));
          chk("stall_out_vld", 128'(bus.out_vld), 128'(1));
          chk("stall_acc", 128'(bus.acc_o), p2(58));
        end
        @(posedge clk_i); #1;
        rdy_mode = 0;
      end
    join_none
    repeat (16) one(1'b0, 1'b0);
    repeat (16) send_pair(1'b0, 0, 1, 0, 2'b01, 1'b0, 0, 0, 0, 2'b01);
    wait_out("stall_b", p2(59), 1'b0);

    repeat (7) one(1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst = 1'b0;
    part = '0; part_nar = 1'b0; part_cnt = 0;
    @(negedge clk_i);
    chk("mid_rst_out_vld", 128'(bus.out_vld), 128'(0));
    chk("mid_rst_in_rdy", 128'(bus.in_rdy), 128'(1));
    @(posedge clk_i); #1;
    repeat (16) one(1'b0, 1'b0);
    wait_out("post_rst", p2(58), 1'b0);

    repeat (16) send_pair(1'b0, 6, 3, 7, 2'b01, 1'b0, 6, 3, 7, 2'b01);
    wait_out("max", 225 * p2(106), 1'b0);
    repeat (16) send_pair(1'b0, -6, 0, 0, 2'b01, 1'b0, -6, 0, 0, 2'b01);
    wait_out("min", 128'(1024), 1'b0);

    rdy_mode = 2;
    for (int g = 0; g < 6 * ACC_LEN; g++) begin
      send_pair(1'($urandom_range(0, 1)), int'($urandom_range(0, 12)) - 6,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), rcls(),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 12)) - 6,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), rcls());
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);
    rdy_mode = 0;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk_i);
    idle(4);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    chk("result_count", 128'(n_out), 128'(n_push));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/posit_mac_accum.md
POSIT_MAC_ACCUM -- requirements
Module: posit_mac_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8, posit bitwidth matching the upstream decoder.
REQ-002 SHALL have parameter EXP, default 2, exponent bits.
REQ-003 SHALL have parameter ACC_LEN, default 16, products per accumulation group (power of two, >=2).
REQ-004 SHALL derive localparams:
- MTS = WIDTH-3-EXP
- REGI = $clog2(WIDTH)+1
- BIAS = 2^(EXP+1)*(WIDTH-2)
- QW = 2*BIAS + 2^(EXP+1) + 2*MTS + $clog2(ACC_LEN) + 1
REQ-005 Ports, clock and reset first (one clock; reset synchronous, active-high):
- clk_i  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous active-high reset
- in_vld  in  1  decoded operand pair valid
- in_rdy  out  1  block accepts the pair this cycle
- sign_s, sign_l  in  1 each  operand signs
- regi_s, regi_l  in  REGI each, signed  regime values
- exp_s, exp_l  in  EXP each  exponent fields
- mts_s, mts_l  in  MTS each  mantissa fields, hidden bit excluded
- vld_o_w, vld_o_d  in  2 each  operand class: 00 zero, 01 valid, 10 NaR
- out_vld  out  1  accumulated result held
- out_rdy  in  1  consumer takes the result
- acc_o  out  QW, signed  fixed-point sum; LSB weight 2^-(BIAS+2*MTS)
- nar_o  out  1  group contained at least one NaR operand

Function
REQ-006 Advance enable en = ~(out_vld & ~out_rdy); in_rdy SHALL equal en; when en=0 every pipeline register, counter and the accumulator SHALL hold.
REQ-007 A pair is accepted when in_vld & in_rdy.
REQ-008 Stage 1 (registered on acceptance), per pair:
- sign = sign_s ^ sign_l
- scale = (regi_s+regi_l)*2^EXP + exp_s + exp_l
- mprod = {1,mts_s}*{1,mts_l}, 2*MTS+2 bits
- zero flag = either class 00
- nar flag = either class 10
- p_vld = 1; when en=1 and no acceptance, p_vld = 0.
REQ-009 Stage 2 term = mprod << (scale+BIAS), sign-extended to QW, two's-complement negated if sign=1; term = 0 when zero or nar flag set.
REQ-010 When p_vld & en, the accumulator SHALL add the term, OR the nar flag into the sticky NaR bit, and increment group counter cnt (0..ACC_LEN-1).
REQ-011 When cnt = ACC_LEN-1 and a term is added:
- acc + term goes to acc_o and sticky|nar goes to nar_o; out_vld = 1
- accumulator, sticky bit and cnt clear to 0 in the same cycle.
REQ-012 Latency: out_vld SHALL rise exactly 2 enabled cycles after the last pair of a group is accepted.
REQ-013 out_vld SHALL clear when out_rdy=1 unless a new group completes that same cycle, in which case the new result loads and out_vld stays 1.
REQ-014 Zero-class products SHALL still count toward ACC_LEN.
REQ-015 Consecutive groups SHALL be separated by no idle cycles when out_rdy is held 1.
REQ-016 Arithmetic SHALL be exact: no rounding, no saturation within one group.

Reset
REQ-017 While rst=1 at a clock edge:
- p_vld, cnt, accumulator, sticky bit, acc_o, nar_o, out_vld cleared to 0
- in-flight stage-1 data discarded
REQ-018 Reset mid-group SHALL discard the partial sum; first pair after reset starts a new group at cnt=0.
REQ-019 in_rdy SHALL be 1 in the first cycle after reset deasserts.

Verification (WIDTH=8, EXP=2, ACC_LEN=16; 1.0 = regi 0, exp 0, mts 0)
REQ-020 16 pairs of 1.0 x 1.0 back-to-back, out_rdy=1 -> out_vld high 2 cycles after the 16th acceptance, acc_o = 2^58, nar_o = 0.
REQ-021 8 pairs of (+1.0)x(+1.0) and 8 pairs of (-1.0)x(+1.0) interleaved -> acc_o = 0, nar_o = 0.
REQ-022 One pair with vld_o_d = 10 among 15 pairs of 1.0 -> nar_o = 1, acc_o = 15*2^54; next group nar_o = 0.
REQ-023 Group completes with out_rdy=0 -> in_rdy = 0 and all state frozen; raising out_rdy -> result taken, next group continues with no lost or duplicated pair.
REQ-024 Assert rst after 7 pairs, then send 16 pairs of 1.0 -> single result 2^58; no result from the 7 pre-reset pairs.
REQ-025 Extremes regi_s = regi_l = 6, exp 3, mts 7 (x16), and regi_s = regi_l = -6, exp 0, mts 0 (x16) -> exact sums 16*225*2^102 and 16*2^6, no overflow.
